// File: rtl/enemy_ctrl_pkg.sv
// Shared types and constants for the enemy controller.
// State encoding, lane numbers and a small sizing helper.
package enemy_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PATROL  = 3'd1,
        WINDUP  = 3'd2,
        STRIKE  = 3'd3,
        RECOVER = 3'd4,
        STUN    = 3'd5,
        KO      = 3'd6
    } state_e;

    localparam logic [1:0] LANE_L = 2'd0;
    localparam logic [1:0] LANE_M = 2'd1;
    localparam logic [1:0] LANE_R = 2'd2;

    function automatic int unsigned max_of(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/enemy_control_if.sv
// Game-side bundle between the enemy FSM and the
// datapath / player logic.
interface enemy_control_if;

    logic       start;
    logic       tick;
    logic       punch_hit;
    logic [1:0] player_lane;
    logic [1:0] x_pos;
    logic       speed;
    logic       attack;
    logic [3:0] hp;
    logic       player_damage;
    logic       ko;

    modport master (
        output start,
        output tick,
        output punch_hit,
        output player_lane,
        input  x_pos,
        input  speed,
        input  attack,
        input  hp,
        input  player_damage,
        input  ko
    );

    modport slave (
        input  start,
        input  tick,
        input  punch_hit,
        input  player_lane,
        output x_pos,
        output speed,
        output attack,
        output hp,
        output player_damage,
        output ko
    );

endinterface

// File: rtl/enemy_lane_stepper.sv
// Ping-pong lane register for the enemy (0,1,2,1,0,...).
// Lane 3 is never produced; a stray value recentres.
module enemy_lane_stepper
    import enemy_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       step_i,
    input  logic       freeze_i,
    input  logic       center_i,
    output logic [1:0] x_pos_o
);

    logic [1:0] x_q, x_d;
    logic       up_q, up_d;

    // Next lane: recentre, or bounce between the outer lanes.
    always_comb begin
        x_d  = x_q;
        up_d = up_q;
        if (center_i) begin
            x_d  = LANE_M;
            up_d = 1'b1;
        end else if (step_i && !freeze_i) begin
            unique case (x_q)
                LANE_L: begin
                    x_d  = LANE_M;
                    up_d = 1'b1;
                end
                LANE_M: x_d = up_q ? LANE_R : LANE_L;
                LANE_R: begin
                    x_d  = LANE_M;
                    up_d = 1'b0;
                end
                default: begin
                    x_d  = LANE_M;
                    up_d = 1'b1;
                end
            endcase
        end
    end

    // Lane and direction registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q  <= LANE_M;
            up_q <= 1'b1;
        end else begin
            x_q  <= x_d;
            up_q <= up_d;
        end
    end

    assign x_pos_o = x_q;

endmodule

// File: rtl/enemy_control.sv
// Enemy behaviour FSM: patrol, wind up, strike, recover,
// take punches. Time base is the datapath tick.
module enemy_control
    import enemy_ctrl_pkg::*;
#(
    parameter int unsigned PATROL_MOVES  = 4,
    parameter int unsigned WINDUP_TICKS  = 3,
    parameter int unsigned RECOVER_TICKS = 2,
    parameter int unsigned STUN_TICKS    = 4,
    parameter int unsigned HP_INIT       = 8,
    parameter int unsigned ENRAGE_HP     = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    enemy_control_if.slave  bus
);

    localparam int unsigned CMAX = max_of(
        max_of(max_of(PATROL_MOVES, WINDUP_TICKS),
               max_of(RECOVER_TICKS, STUN_TICKS)),
        max_of(HP_INIT, ENRAGE_HP));
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] L_PAT = CW'(PATROL_MOVES);
    localparam logic [CW-1:0] L_WND = CW'(WINDUP_TICKS);
    localparam logic [CW-1:0] L_REC = CW'(RECOVER_TICKS);
    localparam logic [CW-1:0] L_STN = CW'(STUN_TICKS);
    localparam logic [3:0]    HP0   = 4'(HP_INIT);
    localparam logic [3:0]    ENR   = 4'(ENRAGE_HP);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    hp_q, hp_d;
    logic          speed_q, speed_d;
    logic          attack_q, attack_d;
    logic          dmg_q, dmg_d;
    logic          ko_q, ko_d;
    logic          step, freeze, center;
    logic [1:0]    x_pos;

    assign cnt_inc = cnt_q + 1'b1;

    // Next state, health and the registered output values.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        dmg_d   = 1'b0;
        step    = 1'b0;
        freeze  = 1'b0;
        unique case (state_q)
            IDLE, KO: begin
                if (bus.start) begin
                    state_d = PATROL;
                    hp_d    = HP0;
                end
            end
            PATROL: begin
                if (bus.tick) begin
                    if (cnt_inc == L_PAT) state_d = WINDUP;
                    else                  step    = 1'b1;
                end
            end
            WINDUP: begin
                freeze = 1'b1;
                if (bus.tick && cnt_inc == L_WND) begin
                    state_d = STRIKE;
                    dmg_d   = (bus.player_lane == x_pos);
                end
            end
            STRIKE: begin
                freeze = 1'b1;
                if (bus.tick) state_d = RECOVER;
            end
            RECOVER: begin
                freeze = 1'b1;
                // A punch outranks a coincident tick.
                if (bus.punch_hit) begin
                    hp_d    = (hp_q != 4'd0) ? hp_q - 4'd1 : 4'd0;
                    state_d = (hp_d == 4'd0) ? KO : STUN;
                end else if (bus.tick && cnt_inc == L_REC) begin
                    state_d = PATROL;
                end
            end
            STUN: begin
                freeze = 1'b1;
                if (bus.tick && cnt_inc == L_STN) state_d = PATROL;
            end
            default: state_d = IDLE;
        endcase

        center = (state_d == IDLE) || (state_d == KO);

        if (state_d != state_q || center) cnt_d = '0;
        else if (bus.tick)                cnt_d = cnt_inc;
        else                              cnt_d = cnt_q;

        speed_d  = (hp_d <= ENR);
        attack_d = (state_d == WINDUP) || (state_d == STRIKE);
        ko_d     = (state_d == KO);
    end

    // State, counter and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hp_q     <= HP0;
            speed_q  <= 1'b0;
            attack_q <= 1'b0;
            dmg_q    <= 1'b0;
            ko_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hp_q     <= hp_d;
            speed_q  <= speed_d;
            attack_q <= attack_d;
            dmg_q    <= dmg_d;
            ko_q     <= ko_d;
        end
    end

    enemy_lane_stepper u_lane (
        .clock    (clock),
        .reset_n  (reset_n),
        .step_i   (step),
        .freeze_i (freeze),
        .center_i (center),
        .x_pos_o  (x_pos)
    );

    assign bus.x_pos         = x_pos;
    assign bus.speed         = speed_q;
    assign bus.attack        = attack_q;
    assign bus.hp            = hp_q;
    assign bus.player_damage = dmg_q;
    assign bus.ko            = ko_q;

endmodule

// File: doc/enemy_control.md
Name: enemy_control

Overview:
- FSM that sequences the enemy datapath for the boxing game.
- Drives the datapath's lane select (x_pos), speed select and attack flag.
- Enemy behaviour cycle: patrol lanes, wind up, strike the player's lane, recover, and take punches (HP, stun, knockout).
- Advances only on the one-cycle tick from the datapath's rate divider; player punches are accepted on any clock.

Parameters:
- PATROL_MOVES, 4: patrol ticks before each wind-up.
- WINDUP_TICKS, 3: ticks attack is held high before the strike.
- RECOVER_TICKS, 2: ticks the enemy is vulnerable after a strike.
- STUN_TICKS, 4: ticks frozen after taking a punch.
- HP_INIT, 8: starting health, 1..15.
- ENRAGE_HP, 4: speed goes to 1 when hp <= this.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; starts or restarts a round from IDLE or KO.
- tick  in  1  one-clock pulse from the rate divider; the time base.
- punch_hit  in  1  one-clock pulse; the player threw a punch.
- player_lane  in  2  lane the player occupies, 0..2; value 3 never matches any lane.
- x_pos  out  2  enemy lane to the datapath: 0=x20, 1=x60, 2=x100. Value 3 is never driven.
- speed  out  1  datapath speed select.
- attack  out  1  high during WINDUP and STRIKE.
- hp  out  4  current enemy health.
- player_damage  out  1  one-clock pulse when the strike lands.
- ko  out  1  high in the KO state.

Behaviour:
- Reset values (asynchronous): state=IDLE, x_pos=1, speed=0, attack=0, hp=HP_INIT, player_damage=0, ko=0, tick_cnt=0, dir=up.
- All outputs are registered. A state change appears one clock after the qualifying input.
- tick_cnt clears on every state entry and increments on each tick within the state.
- Each transition below fires on the tick that brings tick_cnt to the stated limit.
- IDLE: x_pos=1. start -> PATROL, with hp reloaded to HP_INIT.
- PATROL:
  - Each tick steps x_pos in a ping-pong pattern 0,1,2,1,0,1,... dir flips at lanes 0 and 2.
  - After PATROL_MOVES ticks -> WINDUP.
  - punch_hit is ignored (enemy is guarding).
- WINDUP: attack=1, x_pos frozen. After WINDUP_TICKS ticks -> STRIKE.
- STRIKE:
  - Lasts exactly one tick period. attack=1.
  - On entry, compare player_lane with x_pos. If equal, pulse player_damage for exactly one clock.
  - On the next tick -> RECOVER.
- RECOVER:
  - attack=0.
  - punch_hit -> hp decrements. Then hp becomes 0 -> KO, otherwise -> STUN.
  - With no punch, after RECOVER_TICKS ticks -> PATROL.
- STUN: x_pos frozen; punch_hit ignored. After STUN_TICKS ticks -> PATROL.
- KO: ko=1, attack=0, x_pos=1. Only start leaves it: -> PATROL, hp=HP_INIT.
- speed = (hp <= ENRAGE_HP). Updated in the same clock as the hp change. Reloading hp clears it.
- Simultaneous events:
  - punch_hit and tick in the same clock in RECOVER: the punch wins, and the tick is discarded.
  - start in any state other than IDLE or KO: ignored.
- hp saturates at 0 and never wraps.
- reset_n asserted mid-round (any state): immediate return to reset values, and any pending player_damage pulse is dropped.
- tick_cnt is sized to the largest parameter.
- Every state is reachable with the default parameters.

Decomposition:
- Package enemy_ctrl_pkg holds:
  - state encoding localparams: IDLE, PATROL, WINDUP, STRIKE, RECOVER, STUN, KO;
  - lane constants LANE_L=0, LANE_M=1, LANE_R=2.
- Lane-to-pixel mapping (20/60/100) stays in the datapath.
- One sub-module: enemy_lane_stepper. It holds the x_pos/dir ping-pong register, with step and freeze inputs, and guarantees x_pos never equals 3.

Test Plan:
- Reset then start, tick every 4 clocks -> after 4 ticks x_pos reads 1,2,1,0. Then WINDUP with attack=1 held for 3 ticks.
- Strike at x_pos=0 with player_lane=0 -> player_damage high for exactly 1 clock. Repeat with player_lane=2 -> no pulse.
- punch_hit during PATROL, WINDUP and STUN -> hp stays 8. punch_hit during RECOVER -> hp 8->7, state STUN, x_pos frozen for 4 ticks, then PATROL.
- Four punches landed in successive RECOVER windows (hp 8->4) -> speed rises to 1 in the clock hp reaches 4.
- Continue to hp=0 -> ko=1, attack=0, x_pos=1. A later tick changes nothing. start -> hp=8, speed=0, PATROL.
- Boundary cases:
  - punch_hit in the same clock as the final RECOVER tick -> STUN, not PATROL.
  - reset_n pulsed low mid-WINDUP -> all outputs at reset values asynchronously.
